// File: rtl/pc_unit.sv
// Program counter with a circular return-address stack for call/return.
// Stack pointer and entry count are kept separately so a full stack wraps over its oldest entry.
module pc_unit #(
   parameter int unsigned           WIDTH     = 12,
   parameter logic [WIDTH-1:0]      RESET_PC  = '0,
   parameter int unsigned           RAS_DEPTH = 4
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             en,
   input  logic             br_taken,
   input  logic [WIDTH-1:0] br_target,
   input  logic             call,
   input  logic             ret,
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] pc_plus1,
   output logic             ras_empty,
   output logic             ras_full,
   output logic             ras_err
);

   localparam int unsigned PW = $clog2(RAS_DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(RAS_DEPTH);

   logic [WIDTH-1:0] stack [RAS_DEPTH];
   logic [PW-1:0]    sp, sp_next, sp_top;
   logic [CW-1:0]    cnt, cnt_next;
   logic [WIDTH-1:0] pc_next;
   logic             err_next;
   logic             push;

   assign pc_plus1  = pc + 1'b1;
   assign sp_top    = sp - 1'b1;
   assign ras_empty = (cnt == '0);
   assign ras_full  = (cnt == CNT_MAX);

   always_comb begin
      pc_next  = pc;
      sp_next  = sp;
      cnt_next = cnt;
      err_next = ras_err;
      push     = 1'b0;
      if (en) begin
         if (call) begin
            // sp always names the next write slot, so a push on a full stack lands on the oldest entry
            pc_next = br_target;
            push    = 1'b1;
            sp_next = sp + 1'b1;
            if (cnt != CNT_MAX) begin
               cnt_next = cnt + 1'b1;
            end
         end else if (ret) begin
            if (cnt == '0) begin
               pc_next  = pc_plus1;
               err_next = 1'b1;
            end else begin
               pc_next  = stack[sp_top];
               sp_next  = sp_top;
               cnt_next = cnt - 1'b1;
            end
         end else if (br_taken) begin
            pc_next = br_target;
         end else begin
            pc_next = pc_plus1;
         end
      end
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         pc      <= RESET_PC;
         sp      <= '0;
         cnt     <= '0;
         ras_err <= 1'b0;
      end else begin
         pc      <= pc_next;
         sp      <= sp_next;
         cnt     <= cnt_next;
         ras_err <= err_next;
      end
   end

   // Entries are never cleared; count gating keeps stale data unreachable.
   always_ff @(posedge clk) begin
      if (push) begin
         stack[sp] <= pc_plus1;
      end
   end

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit at WIDTH=12, RESET_PC=0, RAS_DEPTH=4.
module tb_pc_unit;

   logic        clk = 1'b0;
   logic        clr = 1'b1;
   logic        en = 1'b0;
   logic        br_taken = 1'b0;
   logic [11:0] br_target = '0;
   logic        call = 1'b0;
   logic        ret = 1'b0;
   logic [11:0] pc;
   logic [11:0] pc_plus1;
   logic        ras_empty;
   logic        ras_full;
   logic        ras_err;

   int unsigned tests = 0;
   int unsigned fails = 0;

   pc_unit #(
      .WIDTH    (12),
      .RESET_PC (12'h000),
      .RAS_DEPTH(4)
   ) dut (
      .clk      (clk),
      .clr      (clr),
      .en       (en),
      .br_taken (br_taken),
      .br_target(br_target),
      .call     (call),
      .ret      (ret),
      .pc       (pc),
      .pc_plus1 (pc_plus1),
      .ras_empty(ras_empty),
      .ras_full (ras_full),
      .ras_err  (ras_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_flags(input string tag, input logic e, input logic f, input logic r);
      check({tag, ".empty"}, {11'b0, ras_empty}, {11'b0, e});
      check({tag, ".full"},  {11'b0, ras_full},  {11'b0, f});
      check({tag, ".err"},   {11'b0, ras_err},   {11'b0, r});
   endtask

   task automatic set_req(input logic c, input logic r, input logic b, input logic [11:0] t);
      call = c;
      ret = r;
      br_taken = b;
      br_target = t;
   endtask

   initial begin
      logic [11:0] tgt;
      logic [11:0] ret_exp [5];

      // reset asserted between edges
      #2 clr = 1'b0;
      #2;
      check("reset.pc", pc, 12'h000);
      check("reset.pc_plus1", pc_plus1, 12'h001);
      check_flags("reset", 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      clr = 1'b1;
      en = 1'b1;

      // sequential run
      tick(); check("seq1", pc, 12'h001);
      tick(); check("seq2", pc, 12'h002);
      tick(); check("seq3", pc, 12'h003);
      check_flags("seq", 1'b1, 1'b0, 1'b0);

      // call then ret
      set_req(1'b0, 1'b0, 1'b1, 12'h010); tick(); check("br010", pc, 12'h010);
      set_req(1'b1, 1'b0, 1'b0, 12'h200); tick(); check("call200", pc, 12'h200);
      check_flags("call200", 1'b0, 1'b0, 1'b0);
      set_req(1'b0, 1'b1, 1'b0, 12'h000); tick(); check("ret011", pc, 12'h011);
      check_flags("ret011", 1'b1, 1'b0, 1'b0);

      // wrap at 0xFFF
      set_req(1'b0, 1'b0, 1'b1, 12'hFFF); tick(); check("brFFF", pc, 12'hFFF);
      check("plus1_wrap", pc_plus1, 12'h000);
      set_req(1'b0, 1'b0, 1'b0, 12'h000); tick(); check("wrap", pc, 12'h000);
      check_flags("wrap", 1'b1, 1'b0, 1'b0);

      // five calls overflow the 4-deep stack, then five rets
      for (int i = 1; i <= 5; i++) begin
         tgt = 12'(i * 12'h100);
         set_req(1'b1, 1'b0, 1'b0, tgt);
         tick();
         check($sformatf("call%0d", i), pc, tgt);
      end
      check_flags("after5calls", 1'b0, 1'b1, 1'b0);
      ret_exp[0] = 12'h401;
      ret_exp[1] = 12'h301;
      ret_exp[2] = 12'h201;
      ret_exp[3] = 12'h101;
      ret_exp[4] = 12'h102;
      for (int i = 0; i < 5; i++) begin
         set_req(1'b0, 1'b1, 1'b0, 12'h000);
         tick();
         check($sformatf("ret%0d", i + 1), pc, ret_exp[i]);
         if (i == 0) check_flags("ret1", 1'b0, 1'b0, 1'b0);
         if (i == 3) check_flags("ret4", 1'b1, 1'b0, 1'b0);
      end
      check_flags("underflow", 1'b1, 1'b0, 1'b1);

      // stall ignores requests
      en = 1'b0;
      set_req(1'b1, 1'b0, 1'b0, 12'h0AA);
      tick(); check("stall1", pc, 12'h102);
      tick(); check("stall2", pc, 12'h102);
      check_flags("stall", 1'b1, 1'b0, 1'b1);

      // call beats ret and br_taken; pushed value returns on next ret
      en = 1'b1;
      set_req(1'b1, 1'b1, 1'b1, 12'h0AA); tick(); check("callwins", pc, 12'h0AA);
      check_flags("callwins", 1'b0, 1'b0, 1'b1);
      set_req(1'b0, 1'b1, 1'b0, 12'h000); tick(); check("ret103", pc, 12'h103);
      check_flags("ret103", 1'b1, 1'b0, 1'b1);

      // async reset during an active call
      set_req(1'b1, 1'b0, 1'b0, 12'h300); tick(); check("precall", pc, 12'h300);
      #3 clr = 1'b0;
      #1;
      check("async.pc", pc, 12'h000);
      check_flags("async", 1'b1, 1'b0, 1'b0);
      tick(); check("held.pc", pc, 12'h000);
      @(negedge clk);
      clr = 1'b1;
      set_req(1'b0, 1'b0, 1'b0, 12'h000);
      tick(); check("post.pc", pc, 12'h001);
      set_req(1'b0, 1'b1, 1'b0, 12'h000); tick(); check("post.ret", pc, 12'h002);
      check_flags("post.ret", 1'b1, 1'b0, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter WIDTH, default 12: PC and address width in bits.
REQ-002 Parameter RESET_PC, default 0: PC value loaded on reset.
REQ-003 Parameter RAS_DEPTH, default 4: return-address-stack entries; SHALL be 2, 4, 8 or 16.
REQ-004 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-005 clr  input  1  reset; asynchronous, active-low; clr=0 SHALL clear immediately, independent of clk.
REQ-006 en  input  1  advance enable; en=0 SHALL stall the PC and stack.
REQ-007 br_taken  input  1  plain branch/jump request.
REQ-008 br_target  input  WIDTH  target address for branch and call.
REQ-009 call  input  1  call request: jump to br_target and push the return address.
REQ-010 ret  input  1  return request: jump to the popped address.
REQ-011 pc  output  WIDTH  current program counter, registered.
REQ-012 pc_plus1  output  WIDTH  (pc+1) mod 2^WIDTH, combinational from pc.
REQ-013 ras_empty  output  1  stack holds 0 entries.
REQ-014 ras_full  output  1  stack holds RAS_DEPTH entries.
REQ-015 ras_err  output  1  sticky underflow flag.

Function
REQ-016 Next-PC priority when en=1: call > ret > br_taken > sequential increment.
REQ-017 Sequential: pc <= (pc+1) mod 2^WIDTH; 2^WIDTH-1 SHALL wrap to 0 with no flag.
REQ-018 br_taken (no call/ret): pc <= br_target; stack unchanged.
REQ-019 call: pc <= br_target; push pc_plus1; count += 1 saturating at RAS_DEPTH.
REQ-020 call while full: push SHALL overwrite the oldest entry (circular); count stays RAS_DEPTH; ras_err unchanged.
REQ-021 ret, stack not empty: pc <= top entry; count -= 1.
REQ-022 ret while empty: pc <= pc_plus1; count stays 0; ras_err <= 1.
REQ-023 call and ret together: call SHALL win; ret ignored, no pop.
REQ-024 en=0: pc, stack contents, count and ras_err SHALL hold; call/ret/br_taken ignored.
REQ-025 Latency: a request sampled at edge N SHALL be visible on pc after edge N; one request per cycle, no back-to-back restriction.
REQ-026 Push followed by pop on the next cycle SHALL return exactly the pushed value.
REQ-027 ras_empty = (count==0); ras_full = (count==RAS_DEPTH); both registered-derived, glitch-free, no combinational path from inputs.
REQ-028 Stack pointer SHALL be a log2(RAS_DEPTH)-bit circular index; count SHALL be a separate log2(RAS_DEPTH)+1-bit counter.
REQ-029 ras_err SHALL clear only on reset.

Reset
REQ-030 clr=0: pc=RESET_PC, count=0, pointer=0, ras_empty=1, ras_full=0, ras_err=0, asynchronously.
REQ-031 Stack entry contents need not be cleared; they SHALL be unobservable until written.
REQ-032 Reset asserted mid-operation (any request active) SHALL override everything; first update after release occurs on the first rising edge with clr=1.
REQ-033 Release of clr SHALL be treated as synchronous to clk by the integrator; no internal synchroniser.

Verification (WIDTH=12, RESET_PC=0, RAS_DEPTH=4)
REQ-034 Reset then 3 cycles en=1, no requests -> pc 0x000, 0x001, 0x002, 0x003; ras_empty=1.
REQ-035 pc=0xFFF, en=1 -> pc=0x000 next cycle; ras_err=0.
REQ-036 pc=0x010, call br_target=0x200; then ret -> pc 0x200, then 0x011; ras_empty=1.
REQ-037 Five calls from pc=0x000 to targets 0x100, 0x200, 0x300, 0x400, 0x500; then five rets -> pc 0x401, 0x301, 0x201, 0x101, then underflow pc=0x102, ras_err=1.
REQ-038 en=0 with call=1, br_target=0x0AA for 2 cycles -> pc and ras_empty unchanged; then call+ret+br_taken with en=1 -> call taken, pc=0x0AA, count=1.
REQ-039 clr driven low between clock edges during a call -> pc=RESET_PC and flags at reset values before the next edge; stack empty afterwards.
